// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - button level to press/auto-repeat event serialiser
//
// Each debounced button level produces one press event on its rising edge.
// While the button is held, it also produces auto-repeat events: the first
// after DELAY_TICKS timebase ticks, then one every REPEAT_TICKS ticks.
// Events from all buttons are merged onto one valid/ready port, with the
// lowest button index taking priority.
//
// Ports:
//   Clk        system clock
//   Rst_n      asynchronous active-low reset
//   BtnClean   debounced button levels, 1 = pressed
//   EvtValid   event present on EvtId/EvtRepeat
//   EvtReady   consumer accepts the event
//   EvtId      button index of the event
//   EvtRepeat  0 = initial press, 1 = auto-repeat
//   EvtDrop    one-cycle pulse, an event was discarded (button already pending)
module key_event_gen #(
   parameter int NBTN         = 4,
   parameter int IDW          = 2,
   parameter int TICK_DIV     = 50000,
   parameter int DELAY_TICKS  = 250,
   parameter int REPEAT_TICKS = 60,
   parameter int CW           = 16
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic [NBTN-1:0] BtnClean,
   output logic            EvtValid,
   input  logic            EvtReady,
   output logic [IDW-1:0]  EvtId,
   output logic            EvtRepeat,
   output logic            EvtDrop
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

   logic [PW-1:0]   pcnt;
   logic            tick;
   state_t          state [NBTN];
   logic [CW-1:0]   tcnt  [NBTN];
   logic [NBTN-1:0] btn_q;
   logic [NBTN-1:0] pending;
   logic [NBTN-1:0] pend_rep;
   logic [NBTN-1:0] req;
   logic [NBTN-1:0] req_rep;
   logic [NBTN-1:0] clr;
   logic            load;
   logic            any_pend;
   logic [IDW-1:0]  sel;

   assign tick = (pcnt == PW'(TICK_DIV - 1));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pcnt <= '0;
      end else if (tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   // A request fires on the tick that would take tcnt to the limit, so
   // comparing against limit-1 before the increment is equivalent.
   always_comb begin
      req     = '0;
      req_rep = '0;
      for (int i = 0; i < NBTN; i++) begin
         case (state[i])
            S_IDLE: begin
               if (BtnClean[i] && !btn_q[i]) req[i] = 1'b1;
            end
            S_DELAY: begin
               if (BtnClean[i] && tick && tcnt[i] == CW'(DELAY_TICKS - 1)) begin
                  req[i]     = 1'b1;
                  req_rep[i] = 1'b1;
               end
            end
            S_REPEAT: begin
               if (BtnClean[i] && tick && tcnt[i] == CW'(REPEAT_TICKS - 1)) begin
                  req[i]     = 1'b1;
                  req_rep[i] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         btn_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            state[i] <= S_IDLE;
            tcnt[i]  <= '0;
         end
      end else begin
         btn_q <= BtnClean;
         for (int i = 0; i < NBTN; i++) begin
            case (state[i])
               S_IDLE: begin
                  if (req[i]) begin
                     tcnt[i]  <= '0;
                     state[i] <= S_DELAY;
                  end
               end
               S_DELAY, S_REPEAT: begin
                  // Release wins over a coincident tick
                  if (!BtnClean[i]) begin
                     state[i] <= S_IDLE;
                  end else if (tick) begin
                     if (req[i]) begin
                        tcnt[i]  <= '0;
                        state[i] <= S_REPEAT;
                     end else begin
                        tcnt[i] <= tcnt[i] + CW'(1);
                     end
                  end
               end
               default: state[i] <= S_IDLE;
            endcase
         end
      end
   end

   // Output load picks the lowest pending index; clr is its one-hot mask.
   always_comb begin
      any_pend = |pending;
      load     = !EvtValid || EvtReady;
      sel      = '0;
      for (int i = NBTN - 1; i >= 0; i--) begin
         if (pending[i]) sel = IDW'(i);
      end
      clr = load ? (pending & (~pending + NBTN'(1))) : '0;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pending   <= '0;
         pend_rep  <= '0;
         EvtValid  <= 1'b0;
         EvtId     <= '0;
         EvtRepeat <= 1'b0;
         EvtDrop   <= 1'b0;
      end else begin
         // A slot being drained this cycle can take a new request (set wins)
         for (int i = 0; i < NBTN; i++) begin
            if (req[i] && (!pending[i] || clr[i])) begin
               pending[i]  <= 1'b1;
               pend_rep[i] <= req_rep[i];
            end else if (clr[i]) begin
               pending[i] <= 1'b0;
            end
         end
         EvtDrop <= |(req & pending & ~clr);
         if (load) begin
            if (any_pend) begin
               EvtValid  <= 1'b1;
               EvtId     <= sel;
               EvtRepeat <= |(pend_rep & clr);
            end else begin
               EvtValid <= 1'b0;
            end
         end
      end
   end

endmodule
